// File: rtl/mem_arbiter.sv
// Two-port round-robin arbiter in front of a single memory slave port.
// One transaction at a time, with a watchdog that ends hung accesses with an error.
module mem_arbiter #(
  parameter int unsigned M_WIDTH        = 32,
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned CNT_WIDTH      = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               cpu_req,
  input  logic               cpu_we,
  input  logic [M_WIDTH-1:0] cpu_addr,
  input  logic [1:0]         cpu_width,
  input  logic [M_WIDTH-1:0] cpu_wdata,
  output logic [M_WIDTH-1:0] cpu_rdata,
  output logic               cpu_ready,
  output logic               cpu_err,
  input  logic               dma_req,
  input  logic [M_WIDTH-1:0] dma_addr,
  input  logic [1:0]         dma_width,
  output logic [M_WIDTH-1:0] dma_rdata,
  output logic               dma_ready,
  output logic               dma_err,
  output logic               mem_req,
  output logic               mem_we,
  output logic [M_WIDTH-1:0] mem_addr,
  output logic [1:0]         mem_width,
  output logic [M_WIDTH-1:0] mem_wdata,
  input  logic [M_WIDTH-1:0] mem_rdata,
  input  logic               mem_ready
);

  localparam logic [1:0] StIdle = 2'd0;
  localparam logic [1:0] StBusy = 2'd1;
  localparam logic [1:0] StDone = 2'd2;

  localparam bit WdogEn = (TIMEOUT_CYCLES != 0);
  localparam logic [CNT_WIDTH-1:0] WdogLast =
      CNT_WIDTH'((TIMEOUT_CYCLES == 0) ? 0 : TIMEOUT_CYCLES - 1);

  logic [1:0]           state_q, state_d;
  logic                 owner_q, owner_d;
  logic                 last_grant_q, last_grant_d;
  logic [CNT_WIDTH-1:0] wdog_q, wdog_d;
  logic                 mem_req_q, mem_req_d;
  logic                 mem_we_q, mem_we_d;
  logic [M_WIDTH-1:0]   mem_addr_q, mem_addr_d;
  logic [1:0]           mem_width_q, mem_width_d;
  logic [M_WIDTH-1:0]   mem_wdata_q, mem_wdata_d;
  logic [M_WIDTH-1:0]   cpu_rdata_q, cpu_rdata_d;
  logic                 cpu_ready_q, cpu_ready_d;
  logic                 cpu_err_q, cpu_err_d;
  logic [M_WIDTH-1:0]   dma_rdata_q, dma_rdata_d;
  logic                 dma_ready_q, dma_ready_d;
  logic                 dma_err_q, dma_err_d;

  logic grant_dma;
  logic wdog_hit;

  // On contention the port that did not win last time gets the grant.
  assign grant_dma = dma_req & (~cpu_req | ~last_grant_q);
  assign wdog_hit  = WdogEn & (wdog_q == WdogLast);

  always_comb begin
    state_d      = state_q;
    owner_d      = owner_q;
    last_grant_d = last_grant_q;
    wdog_d       = wdog_q;
    mem_req_d    = mem_req_q;
    mem_we_d     = mem_we_q;
    mem_addr_d   = mem_addr_q;
    mem_width_d  = mem_width_q;
    mem_wdata_d  = mem_wdata_q;
    cpu_rdata_d  = cpu_rdata_q;
    cpu_ready_d  = 1'b0;
    cpu_err_d    = 1'b0;
    dma_rdata_d  = dma_rdata_q;
    dma_ready_d  = 1'b0;
    dma_err_d    = 1'b0;

    case (state_q)
      StIdle: begin
        if (cpu_req || dma_req) begin
          owner_d      = grant_dma;
          last_grant_d = grant_dma;
          mem_req_d    = 1'b1;
          mem_we_d     = grant_dma ? 1'b0 : cpu_we;
          mem_addr_d   = grant_dma ? dma_addr : cpu_addr;
          mem_width_d  = grant_dma ? dma_width : cpu_width;
          mem_wdata_d  = grant_dma ? '0 : cpu_wdata;
          wdog_d       = '0;
          state_d      = StBusy;
        end
      end
      StBusy: begin
        wdog_d = wdog_q + CNT_WIDTH'(1);
        // A response arriving on the timeout cycle still counts as success.
        if (mem_ready || wdog_hit) begin
          if (owner_q) begin
            dma_rdata_d = mem_ready ? mem_rdata : '0;
            dma_ready_d = 1'b1;
            dma_err_d   = ~mem_ready;
          end else begin
            cpu_rdata_d = mem_ready ? mem_rdata : '0;
            cpu_ready_d = 1'b1;
            cpu_err_d   = ~mem_ready;
          end
          mem_req_d = 1'b0;
          state_d   = StDone;
        end
      end
      StDone: state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= StIdle;
      owner_q      <= 1'b0;
      last_grant_q <= 1'b1;
      wdog_q       <= '0;
      mem_req_q    <= 1'b0;
      mem_we_q     <= 1'b0;
      mem_addr_q   <= '0;
      mem_width_q  <= '0;
      mem_wdata_q  <= '0;
      cpu_rdata_q  <= '0;
      cpu_ready_q  <= 1'b0;
      cpu_err_q    <= 1'b0;
      dma_rdata_q  <= '0;
      dma_ready_q  <= 1'b0;
      dma_err_q    <= 1'b0;
    end else begin
      state_q      <= state_d;
      owner_q      <= owner_d;
      last_grant_q <= last_grant_d;
      wdog_q       <= wdog_d;
      mem_req_q    <= mem_req_d;
      mem_we_q     <= mem_we_d;
      mem_addr_q   <= mem_addr_d;
      mem_width_q  <= mem_width_d;
      mem_wdata_q  <= mem_wdata_d;
      cpu_rdata_q  <= cpu_rdata_d;
      cpu_ready_q  <= cpu_ready_d;
      cpu_err_q    <= cpu_err_d;
      dma_rdata_q  <= dma_rdata_d;
      dma_ready_q  <= dma_ready_d;
      dma_err_q    <= dma_err_d;
    end
  end

  assign mem_req   = mem_req_q;
  assign mem_we    = mem_we_q;
  assign mem_addr  = mem_addr_q;
  assign mem_width = mem_width_q;
  assign mem_wdata = mem_wdata_q;
  assign cpu_rdata = cpu_rdata_q;
  assign cpu_ready = cpu_ready_q;
  assign cpu_err   = cpu_err_q;
  assign dma_rdata = dma_rdata_q;
  assign dma_ready = dma_ready_q;
  assign dma_err   = dma_err_q;

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table plus multi-cycle sequences, checked through
// grant/completion scoreboards fed by a negedge monitor and a latency-programmable slave.
module tb_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        cpu_req, cpu_we, cpu_ready, cpu_err;
  logic [31:0] cpu_addr, cpu_wdata, cpu_rdata;
  logic [1:0]  cpu_width;
  logic        dma_req, dma_ready, dma_err;
  logic [31:0] dma_addr, dma_rdata;
  logic [1:0]  dma_width;
  logic        mem_req, mem_we, mem_ready;
  logic [31:0] mem_addr, mem_wdata, mem_rdata;
  logic [1:0]  mem_width;

  mem_arbiter #(
    .M_WIDTH       (32),
    .TIMEOUT_CYCLES(4),
    .CNT_WIDTH     (8)
  ) dut (
    .clk      (clk),
    .rst      (rst),
    .cpu_req  (cpu_req),
    .cpu_we   (cpu_we),
    .cpu_addr (cpu_addr),
    .cpu_width(cpu_width),
    .cpu_wdata(cpu_wdata),
    .cpu_rdata(cpu_rdata),
    .cpu_ready(cpu_ready),
    .cpu_err  (cpu_err),
    .dma_req  (dma_req),
    .dma_addr (dma_addr),
    .dma_width(dma_width),
    .dma_rdata(dma_rdata),
    .dma_ready(dma_ready),
    .dma_err  (dma_err),
    .mem_req  (mem_req),
    .mem_we   (mem_we),
    .mem_addr (mem_addr),
    .mem_width(mem_width),
    .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata),
    .mem_ready(mem_ready)
  );

  typedef struct {
    logic        dma;
    logic        we;
    logic [31:0] addr;
    logic [1:0]  width;
    logic [31:0] wdata;
    int          lat;
    logic [31:0] sdata;
    logic        exp_we;
    logic [31:0] exp_wdata;
    int          exp_busy;
    logic [31:0] exp_rdata;
    logic        exp_err;
  } vec_t;

  typedef struct {
    logic [31:0] addr;
    logic        we;
    logic [1:0]  width;
    logic [31:0] wdata;
    int          busy;
  } grant_t;

  typedef struct {
    logic        dma;
    logic [31:0] rdata;
    logic        err;
  } done_t;

  grant_t exp_grant[$];
  done_t  exp_done[$];
  vec_t   vecs[8];

  int n_checks = 0;
  int n_fail   = 0;
  int n_grants = 0;

  bit          mon_en = 0;
  bit          slave_force = 0;
  int          slave_lat = 2;
  int          slave_cnt = 0;
  logic [31:0] slave_data = '0;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #100000;
    $display("FAIL global_timeout: simulation still running, required finish");
    $fatal(1, "bench timeout");
  end

  function automatic void check(input string name, input logic [31:0] act,
                                input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endfunction

  // Slave: asserts mem_ready on the slave_lat-th BUSY cycle; slave_lat 0 never answers.
  initial begin
    mem_ready = 1'b0;
    mem_rdata = 32'hBAD0_BAD0;
    forever begin
      @(negedge clk);
      if (slave_force) begin
        mem_ready = 1'b1;
        mem_rdata = 32'hDEAD_0000;
      end else if (mem_req === 1'b1) begin
        slave_cnt++;
        if (slave_lat != 0 && slave_cnt == slave_lat) begin
          mem_ready = 1'b1;
          mem_rdata = slave_data;
        end else begin
          mem_ready = 1'b0;
          mem_rdata = 32'hBAD0_BAD0;
        end
      end else begin
        slave_cnt = 0;
        mem_ready = 1'b0;
        mem_rdata = 32'hBAD0_BAD0;
      end
    end
  end

  // Monitor: pops the grant queue on each mem_req rise, the done queue on each ready pulse.
  initial begin
    grant_t      cur;
    done_t       d;
    int          busy_cnt = 0;
    logic        prev_req = 1'b0;
    logic        prev_cpu_rdy = 1'b0;
    logic        prev_dma_rdy = 1'b0;
    logic [31:0] last_cpu = '0;
    logic [31:0] last_dma = '0;
    cur = '{addr: '0, we: 1'b0, width: 2'd0, wdata: '0, busy: 0};
    forever begin
      @(negedge clk);
      if (rst) begin
        last_cpu = '0;
        last_dma = '0;
      end
      if (mon_en) begin
        if (mem_req && !prev_req) begin
          n_grants++;
          busy_cnt = 1;
          if (exp_grant.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_grant: got addr %h want no grant", mem_addr);
          end else begin
            cur = exp_grant.pop_front();
            check("grant_addr", mem_addr, cur.addr);
            check("grant_we", 32'(mem_we), 32'(cur.we));
            check("grant_width", 32'(mem_width), 32'(cur.width));
            check("grant_wdata", mem_wdata, cur.wdata);
          end
        end else if (mem_req) begin
          busy_cnt++;
          check("hold_addr", mem_addr, cur.addr);
        end else if (prev_req) begin
          check("busy_len", 32'(busy_cnt), 32'(cur.busy));
        end
        prev_req = mem_req;

        if (cpu_ready || dma_ready) begin
          check("ready_pulse_width", 32'({prev_cpu_rdy & cpu_ready, prev_dma_rdy & dma_ready}),
                32'd0);
          if (exp_done.size() == 0) begin
            n_checks++;
            n_fail++;
            $display("FAIL unexpected_ready: got cpu=%b dma=%b want none", cpu_ready, dma_ready);
          end else begin
            d = exp_done.pop_front();
            check("ready_owner", 32'({cpu_ready, dma_ready}), d.dma ? 32'd1 : 32'd2);
            if (d.dma) begin
              check("dma_rdata", dma_rdata, d.rdata);
              check("dma_err", 32'(dma_err), 32'(d.err));
              check("cpu_err_quiet", 32'(cpu_err), 32'd0);
              check("cpu_rdata_hold", cpu_rdata, last_cpu);
              last_dma = d.rdata;
            end else begin
              check("cpu_rdata", cpu_rdata, d.rdata);
              check("cpu_err", 32'(cpu_err), 32'(d.err));
              check("dma_err_quiet", 32'(dma_err), 32'd0);
              check("dma_rdata_hold", dma_rdata, last_dma);
              last_cpu = d.rdata;
            end
          end
        end else if (cpu_err || dma_err) begin
          check("err_without_ready", 32'({cpu_err, dma_err}), 32'd0);
        end
        prev_cpu_rdy = cpu_ready;
        prev_dma_rdy = dma_ready;
      end
    end
  end

  task automatic wait_ready(input bit dma, input string name);
    bit seen = 1'b0;
    for (int i = 0; i < 40 && !seen; i++) begin
      @(negedge clk);
      seen = dma ? (dma_ready === 1'b1) : (cpu_ready === 1'b1);
    end
    n_checks++;
    if (!seen) begin
      n_fail++;
      $display("FAIL %s: got no ready within 40 cycles want ready pulse", name);
    end
  endtask

  task automatic push_txn(input logic [31:0] addr, input logic we, input logic [1:0] width,
                          input logic [31:0] wdata, input int busy, input logic dma,
                          input logic [31:0] rdata, input logic err);
    exp_grant.push_back('{addr: addr, we: we, width: width, wdata: wdata, busy: busy});
    exp_done.push_back('{dma: dma, rdata: rdata, err: err});
  endtask

  task automatic apply_vec(input vec_t v);
    slave_lat  = v.lat;
    slave_data = v.sdata;
    cpu_we     = v.we;
    cpu_wdata  = v.wdata;
    cpu_width  = v.width;
    dma_width  = v.width;
    cpu_addr   = v.dma ? 32'hFFFF_0000 : v.addr;
    dma_addr   = v.dma ? v.addr : 32'hEEEE_0000;
    push_txn(v.addr, v.exp_we, v.width, v.exp_wdata, v.exp_busy, v.dma, v.exp_rdata, v.exp_err);
    if (v.dma) dma_req = 1'b1;
    else cpu_req = 1'b1;
    @(negedge clk);
    check("pre_grant_idle", 32'(mem_req), 32'd0);
    @(negedge clk);
    check("grant_latency", 32'(mem_req), 32'd1);
    wait_ready(v.dma, "vec_ready");
    @(posedge clk);
    #1;
    cpu_req = 1'b0;
    dma_req = 1'b0;
    @(posedge clk);
    #1;
  endtask

  task automatic check_reset_state();
    check("rst_mem_req", 32'(mem_req), 32'd0);
    check("rst_mem_we", 32'(mem_we), 32'd0);
    check("rst_mem_addr", mem_addr, 32'd0);
    check("rst_ready", 32'({cpu_ready, dma_ready}), 32'd0);
    check("rst_err", 32'({cpu_err, dma_err}), 32'd0);
    check("rst_cpu_rdata", cpu_rdata, 32'd0);
    check("rst_dma_rdata", dma_rdata, 32'd0);
  endtask

  initial begin
    int g0;
    vecs[0] = '{1'b0, 1'b1, 32'h100, 2'd2, 32'hDEADBEEF, 2, 32'h12345678,
                1'b1, 32'hDEADBEEF, 2, 32'h12345678, 1'b0};
    vecs[1] = '{1'b1, 1'b1, 32'h200, 2'd0, 32'hFFFFFFFF, 2, 32'h00000041,
                1'b0, 32'h0, 2, 32'h00000041, 1'b0};
    vecs[2] = '{1'b0, 1'b0, 32'h104, 2'd1, 32'h0, 1, 32'hCAFE0001,
                1'b0, 32'h0, 1, 32'hCAFE0001, 1'b0};
    vecs[3] = '{1'b0, 1'b0, 32'h108, 2'd2, 32'h0, 0, 32'h99999999,
                1'b0, 32'h0, 4, 32'h0, 1'b1};
    vecs[4] = '{1'b0, 1'b0, 32'h10C, 2'd2, 32'h0, 4, 32'h600DF00D,
                1'b0, 32'h0, 4, 32'h600DF00D, 1'b0};
    vecs[5] = '{1'b1, 1'b0, 32'h204, 2'd3, 32'h0, 0, 32'h00000005,
                1'b0, 32'h0, 4, 32'h0, 1'b1};
    vecs[6] = '{1'b1, 1'b1, 32'h208, 2'd1, 32'h1234, 3, 32'h00000077,
                1'b0, 32'h0, 3, 32'h00000077, 1'b0};
    vecs[7] = '{1'b0, 1'b1, 32'h010, 2'd0, 32'hAB, 5, 32'h0F0F0F0F,
                1'b1, 32'hAB, 4, 32'h0, 1'b1};

    rst = 1'b1;
    cpu_req = 1'b0; cpu_we = 1'b0; cpu_addr = '0; cpu_width = '0; cpu_wdata = '0;
    dma_req = 1'b0; dma_addr = '0; dma_width = '0;
    @(posedge clk);
    #1 mon_en = 1'b1;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_state();
    @(posedge clk);
    #1;

    for (int i = 0; i < 8; i++) apply_vec(vecs[i]);

    // Both ports requesting back to back from reset: CPU, DMA, CPU, DMA.
    rst = 1'b1;
    @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check_reset_state();
    @(posedge clk);
    #1;
    slave_lat = 2;
    slave_data = 32'h5A5A_0001;
    cpu_we = 1'b0; cpu_width = 2'd2; cpu_wdata = '0; dma_width = 2'd0;
    push_txn(32'h100, 1'b0, 2'd2, 32'h0, 2, 1'b0, 32'h5A5A_0001, 1'b0);
    push_txn(32'h200, 1'b0, 2'd0, 32'h0, 2, 1'b1, 32'h5A5A_0001, 1'b0);
    push_txn(32'h104, 1'b0, 2'd2, 32'h0, 2, 1'b0, 32'h5A5A_0001, 1'b0);
    push_txn(32'h204, 1'b0, 2'd0, 32'h0, 2, 1'b1, 32'h5A5A_0001, 1'b0);
    fork
      begin
        for (int k = 0; k < 2; k++) begin
          cpu_addr = 32'h100 + 32'(4 * k);
          cpu_req = 1'b1;
          wait_ready(1'b0, "fair_cpu_ready");
          @(posedge clk);
          #1;
        end
        cpu_req = 1'b0;
      end
      begin
        for (int k = 0; k < 2; k++) begin
          dma_addr = 32'h200 + 32'(4 * k);
          dma_req = 1'b1;
          wait_ready(1'b1, "fair_dma_ready");
          @(posedge clk);
          #1;
        end
        dma_req = 1'b0;
      end
    join
    @(posedge clk);
    #1;

    // UART-style DMA byte reads, req dropped the cycle after each ready.
    g0 = n_grants;
    for (int i = 0; i < 8; i++) begin
      dma_addr = 32'h300 + 32'(i);
      dma_width = 2'd0;
      slave_lat = 1 + (i % 3);
      slave_data = 32'h30 + 32'(i);
      push_txn(dma_addr, 1'b0, 2'd0, 32'h0, slave_lat, 1'b1, slave_data, 1'b0);
      dma_req = 1'b1;
      wait_ready(1'b1, "uart_ready");
      @(posedge clk);
      #1 dma_req = 1'b0;
      @(posedge clk);
      #1;
    end
    check("uart_grant_count", 32'(n_grants - g0), 32'd8);

    // mem_ready strobing while idle must not produce anything.
    slave_force = 1'b1;
    repeat (3) begin
      @(negedge clk);
      check("idle_ready_ignored", 32'({mem_req, cpu_ready, dma_ready}), 32'd0);
    end
    slave_force = 1'b0;
    @(posedge clk);
    #1;

    // Reset during the second BUSY cycle of a DMA read, then both request.
    slave_lat = 0;
    slave_data = 32'h0000_0BB0;
    dma_addr = 32'h20C;
    dma_width = 2'd2;
    exp_grant.push_back('{addr: 32'h20C, we: 1'b0, width: 2'd2, wdata: 32'h0, busy: 2});
    dma_req = 1'b1;
    @(posedge clk);
    @(posedge clk);
    #1;
    rst = 1'b1;
    cpu_req = 1'b1; cpu_we = 1'b0; cpu_addr = 32'h110; cpu_width = 2'd2; cpu_wdata = '0;
    @(posedge clk);
    #1;
    rst = 1'b0;
    slave_lat = 1;
    push_txn(32'h110, 1'b0, 2'd2, 32'h0, 1, 1'b0, 32'h0000_0BB0, 1'b0);
    push_txn(32'h20C, 1'b0, 2'd2, 32'h0, 1, 1'b1, 32'h0000_0BB0, 1'b0);
    @(negedge clk);
    check("rst_busy_mem_req", 32'(mem_req), 32'd0);
    check("rst_busy_no_ready", 32'({dma_ready, dma_err}), 32'd0);
    wait_ready(1'b0, "post_rst_cpu_ready");
    @(posedge clk);
    #1 cpu_req = 1'b0;
    wait_ready(1'b1, "post_rst_dma_ready");
    @(posedge clk);
    #1 dma_req = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    check("grant_total", 32'(n_grants), 32'd23);
    check("grant_queue_empty", 32'(exp_grant.size()), 32'd0);
    check("done_queue_empty", 32'(exp_done.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule
